// File: rtl/modn_updown_load_counter.sv
// Modulo-MOD up/down counter with synchronous load, synchronous clear,
// count enable and a cascade terminal-count output.
// Optional feature macro: MODN_UPDOWN_LOAD_COUNTER_WRAP_CNT_EN adds a
// saturating 16-bit wrap counter output (wrap_cnt).
module modn_updown_load_counter #(
    parameter int unsigned MOD     = 12,
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] count,
    output logic             tc,
`ifdef MODN_UPDOWN_LOAD_COUNTER_WRAP_CNT_EN
    output logic [15:0]      wrap_cnt,
`endif
    output logic             load_err
);

    // Reject illegal parameter combinations at elaboration
    if (MOD < 2) begin : g_bad_mod
        $fatal(1, "modn_updown_load_counter: MOD must be >= 2");
    end
    if (64'(MOD) > (64'd1 << WIDTH)) begin : g_bad_width
        $fatal(1, "modn_updown_load_counter: 2**WIDTH must be >= MOD");
    end
    if (RST_VAL >= MOD) begin : g_bad_rst
        $fatal(1, "modn_updown_load_counter: RST_VAL must be < MOD");
    end

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(RST_VAL);

    logic             load_bad;
    logic             at_top;
    logic             at_bottom;
    logic [WIDTH-1:0] count_nxt;
    logic             load_err_nxt;

    // Range check against MOD-1 so that MOD == 2**WIDTH never rejects
    assign load_bad  = (d_in > MAX_VAL);
    assign at_top    = (count == MAX_VAL);
    assign at_bottom = (count == '0);

    // Terminal count: asserted in the cycle whose next edge wraps
    assign tc = en && !clr && !load && (up_dn ? at_top : at_bottom);

    // Next-state selection in priority order: clr, load, count, hold
    always_comb begin
        count_nxt    = count;
        load_err_nxt = 1'b0;
        if (clr) begin
            count_nxt = INIT_VAL;
        end else if (load) begin
            if (load_bad) begin
                load_err_nxt = 1'b1;
            end else begin
                count_nxt = d_in;
            end
        end else if (en) begin
            if (up_dn) begin
                count_nxt = at_top ? '0 : count + WIDTH'(1);
            end else begin
                count_nxt = at_bottom ? MAX_VAL : count - WIDTH'(1);
            end
        end
    end

    // Count and load-error registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= INIT_VAL;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            load_err <= load_err_nxt;
        end
    end

`ifdef MODN_UPDOWN_LOAD_COUNTER_WRAP_CNT_EN
    // Saturating count of wrap events; cleared by reset and clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_cnt <= '0;
        end else if (clr) begin
            wrap_cnt <= '0;
        end else if (tc && (wrap_cnt != '1)) begin
            wrap_cnt <= wrap_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_modn_updown_load_counter.sv
// Directed self-checking bench for modn_updown_load_counter.
// Three instances share stimulus: MOD=12 (main), MOD=16/RST_VAL=3, MOD=60.
module tb_modn_updown_load_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       clr;
    logic       load;
    logic [5:0] d_in;

    logic [3:0] count_a;
    logic       tc_a;
    logic       load_err_a;
    logic [3:0] count_b;
    logic       tc_b;
    logic       load_err_b;
    logic [5:0] count_c;
    logic       tc_c;
    logic       load_err_c;
`ifdef MODN_UPDOWN_LOAD_COUNTER_WRAP_CNT_EN
    logic [15:0] wrap_a;
    logic [15:0] wrap_b;
    logic [15:0] wrap_c;
`endif

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned exp_cnt;

    modn_updown_load_counter #(.MOD(12), .WIDTH(4), .RST_VAL(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .d_in(d_in[3:0]), .count(count_a), .tc(tc_a),
`ifdef MODN_UPDOWN_LOAD_COUNTER_WRAP_CNT_EN
        .wrap_cnt(wrap_a),
`endif
        .load_err(load_err_a)
    );

    modn_updown_load_counter #(.MOD(16), .WIDTH(4), .RST_VAL(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .d_in(d_in[3:0]), .count(count_b), .tc(tc_b),
`ifdef MODN_UPDOWN_LOAD_COUNTER_WRAP_CNT_EN
        .wrap_cnt(wrap_b),
`endif
        .load_err(load_err_b)
    );

    modn_updown_load_counter #(.MOD(60), .WIDTH(6), .RST_VAL(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .d_in(d_in), .count(count_c), .tc(tc_c),
`ifdef MODN_UPDOWN_LOAD_COUNTER_WRAP_CNT_EN
        .wrap_cnt(wrap_c),
`endif
        .load_err(load_err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        up_dn = 1'b1;
        clr   = 1'b0;
        load  = 1'b0;
        d_in  = '0;

        #12;
        check("rst_count_a", 32'(count_a), 0);
        check("rst_err_a", 32'(load_err_a), 0);
        check("rst_count_b", 32'(count_b), 3);

        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        up_dn = 1'b1;

        // Up count 13 edges: 1..11, 0, 1; tc only while count == 11
        exp_cnt = 0;
        for (int i = 1; i <= 13; i++) begin
            #1;
            check("up_tc", 32'(tc_a), (exp_cnt == 11) ? 1 : 0);
            step();
            exp_cnt = (exp_cnt + 1) % 12;
            check("up_count", 32'(count_a), exp_cnt);
        end
        check("up_end", 32'(count_a), 1);

        step();
        check("to_two", 32'(count_a), 2);

        // Down count from 2: 1, 0, 11, 10; tc while count == 0
        up_dn = 1'b0;
        exp_cnt = 2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("dn_tc", 32'(tc_a), (exp_cnt == 0) ? 1 : 0);
            step();
            exp_cnt = (exp_cnt == 0) ? 11 : exp_cnt - 1;
            check("dn_count", 32'(count_a), exp_cnt);
        end
        check("dn_end", 32'(count_a), 10);

        up_dn = 1'b1;
        step();
        check("flip_up", 32'(count_a), 11);

        // Valid load at terminal value: no wrap, tc suppressed
        load = 1'b1;
        d_in = 6'd5;
        #1;
        check("load_tc", 32'(tc_a), 0);
        step();
        check("load5", 32'(count_a), 5);
        check("load5_err", 32'(load_err_a), 0);

        // Out-of-range load: hold and one-cycle error pulse
        d_in = 6'd12;
        step();
        check("load12_hold", 32'(count_a), 5);
        check("load12_err", 32'(load_err_a), 1);
        load = 1'b0;
        en   = 1'b0;
        step();
        check("load12_pulse_end", 32'(load_err_a), 0);
        load = 1'b1;
        d_in = 6'd15;
        step();
        check("load15_hold", 32'(count_a), 5);
        check("load15_err", 32'(load_err_a), 1);
        check("b_load15_ok", 32'(count_b), 15);
        check("b_load15_err", 32'(load_err_b), 0);
        load = 1'b0;
        step();
        check("load15_pulse_end", 32'(load_err_a), 0);

        // clr beats an invalid load and enable
        clr  = 1'b1;
        load = 1'b1;
        d_in = 6'd13;
        en   = 1'b1;
        #1;
        check("clr_tc", 32'(tc_a), 0);
        step();
        check("clr_count", 32'(count_a), 0);
        check("clr_err", 32'(load_err_a), 0);
        check("clr_count_b", 32'(count_b), 3);

        // Enable low holds the count
        clr  = 1'b0;
        d_in = 6'd7;
        step();
        check("load7", 32'(count_a), 7);
        load = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_tc", 32'(tc_a), 0);
            step();
            check("hold_count", 32'(count_a), 7);
        end

        // Asynchronous reset mid-count takes effect without a clock edge
        en = 1'b1;
        step();
        check("pre_rst", 32'(count_a), 8);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", 32'(count_a), 0);
        check("async_rst_b", 32'(count_b), 3);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_a", 32'(count_a), 1);
        check("post_rst_b", 32'(count_b), 4);

        // Sixteen-state instance: wrap 15 -> 0
        load = 1'b1;
        d_in = 6'd15;
        step();
        load = 1'b0;
        #1;
        check("b_tc", 32'(tc_b), 1);
        step();
        check("b_wrap", 32'(count_b), 0);

        // Sixty-state instance: wrap 59 -> 0, and 60 rejected
        load = 1'b1;
        d_in = 6'd59;
        step();
        load = 1'b0;
        check("c_load59", 32'(count_c), 59);
        #1;
        check("c_tc", 32'(tc_c), 1);
        step();
        check("c_wrap", 32'(count_c), 0);
        load = 1'b1;
        d_in = 6'd60;
        step();
        load = 1'b0;
        check("c_load60_hold", 32'(count_c), 0);
        check("c_load60_err", 32'(load_err_c), 1);

`ifdef MODN_UPDOWN_LOAD_COUNTER_WRAP_CNT_EN
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("wrap_clr0", 32'(wrap_a), 0);
        up_dn = 1'b1;
        for (int i = 0; i < 30; i++) step();
        check("wrap30_count", 32'(count_a), 6);
        check("wrap30", 32'(wrap_a), 2);
        load = 1'b1;
        d_in = 6'd11;
        step();
        load = 1'b0;
        check("wrap_load", 32'(wrap_a), 2);
        step();
        check("wrap_after_load", 32'(wrap_a), 3);
        check("wrap_after_load_cnt", 32'(count_a), 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("wrap_clr", 32'(wrap_a), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
